// File: rtl/frac_uart_tx.sv
// Tick-paced UART transmitter: valid/ready word in, framed serial line out.
// Bit period is a whole number of tick pulses; the tick may be fractional.
module frac_uart_tx #(
  parameter int DATA_W        = 8,
  parameter int TICKS_PER_BIT = 1,
  parameter int PARITY_EN     = 0,
  parameter int PARITY_ODD    = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tick,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int TW = $clog2(TICKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_W) + 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state, state_n;
  logic [TW-1:0]     tick_cnt, tick_cnt_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              par, par_n;
  logic              tx_n, ready_n, busy_n, done_n;
  logic              bit_end;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      tx        <= 1'b1;
      din_ready <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      par       <= par_n;
      tx        <= tx_n;
      din_ready <= ready_n;
      busy      <= busy_n;
      tx_done   <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    par_n      = par;
    tx_n       = tx;
    ready_n    = din_ready;
    busy_n     = busy;
    done_n     = 1'b0;
    bit_end    = 1'b0;

    // Bit timing only runs once the start bit is on the line
    if (state != IDLE && state != ALIGN && tick) begin
      if (tick_cnt == TICK_LAST) begin
        bit_end    = 1'b1;
        tick_cnt_n = '0;
      end else begin
        tick_cnt_n = tick_cnt + TW'(1);
      end
    end

    unique case (state)
      IDLE: begin
        if (din_valid && din_ready) begin
          shreg_n = din;
          par_n   = ^din ^ ODD;
          ready_n = 1'b0;
          busy_n  = 1'b1;
          state_n = ALIGN;
        end
      end
      ALIGN: begin
        if (tick) begin
          tx_n       = 1'b0;
          tick_cnt_n = '0;
          state_n    = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_n      = shreg[0];
          bit_cnt_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_n = '0;
            if (PARITY_EN != 0) begin
              tx_n    = par;
              state_n = PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = STOP;
            end
          end else begin
            shreg_n   = shreg >> 1;
            tx_n      = shreg[1];
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_n      = 1'b1;
          bit_cnt_n = '0;
          state_n   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_n = '0;
            done_n    = 1'b1;
            busy_n    = 1'b0;
            ready_n   = 1'b1;
            state_n   = IDLE;
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_frac_uart_tx.sv
// Directed bench for frac_uart_tx: frame tables plus reset,
// back-to-back and coincident-tick sequences over four configurations.
module tb_frac_uart_tx;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] din = 8'h00;
  logic [3:0] v = 4'b0000;
  logic [3:0] rdy_w, tx_w, bsy_w, dn_w;

  int sel = 0;
  logic tx_s, rdy_s, bsy_s, dn_s;
  assign tx_s  = tx_w[sel];
  assign rdy_s = rdy_w[sel];
  assign bsy_s = bsy_w[sel];
  assign dn_s  = dn_w[sel];

  always #5 clk = ~clk;

  frac_uart_tx u0 (
    .clk(clk), .rstn(rstn), .tick(tick), .din(din), .din_valid(v[0]),
    .din_ready(rdy_w[0]), .tx(tx_w[0]), .busy(bsy_w[0]), .tx_done(dn_w[0])
  );
  frac_uart_tx #(.PARITY_EN(1)) u1 (
    .clk(clk), .rstn(rstn), .tick(tick), .din(din), .din_valid(v[1]),
    .din_ready(rdy_w[1]), .tx(tx_w[1]), .busy(bsy_w[1]), .tx_done(dn_w[1])
  );
  frac_uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rstn(rstn), .tick(tick), .din(din), .din_valid(v[2]),
    .din_ready(rdy_w[2]), .tx(tx_w[2]), .busy(bsy_w[2]), .tx_done(dn_w[2])
  );
  frac_uart_tx #(.TICKS_PER_BIT(3), .STOP_BITS(2)) u3 (
    .clk(clk), .rstn(rstn), .tick(tick), .din(din), .din_valid(v[3]),
    .din_ready(rdy_w[3]), .tx(tx_w[3]), .busy(bsy_w[3]), .tx_done(dn_w[3])
  );

  // tmode: 0 = no tick, N>0 = every N clk, -1 = 76/10 fractional divider
  int tmode = 0;
  int tcnt = 0;
  int facc = 0;
  always @(negedge clk) begin
    if (tmode > 0) begin
      if (tcnt >= tmode - 1) begin
        tcnt = 0;
        tick = 1'b1;
      end else begin
        tcnt = tcnt + 1;
        tick = 1'b0;
      end
    end else if (tmode < 0) begin
      facc = facc + 10;
      if (facc >= 76) begin
        facc = facc - 76;
        tick = 1'b1;
      end else begin
        tick = 1'b0;
      end
    end else begin
      tick = 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input int d, input logic [7:0] data);
    sel = d;
    @(negedge clk);
    #1;
    din  = data;
    v[d] = 1'b1;
    @(posedge clk);
    #1;
    v[d] = 1'b0;
    check("accept", {rdy_s, bsy_s}, 2'b01);
  endtask

  // Records tx after every tick edge from the start bit up to tx_done
  task automatic capture(output logic [63:0] got, output int n,
                         output int clks, output int lead,
                         output int gmin, output int gmax, output int ok);
    bit started = 0;
    bit fin = 0;
    int last = 0;
    got = '0; n = 0; clks = 0; lead = 0; gmin = 999; gmax = 0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      @(posedge clk);
      #1;
      if (!started) lead++;
      else clks++;
      if (tick) begin
        if (started) begin
          if (clks - last < gmin) gmin = clks - last;
          if (clks - last > gmax) gmax = clks - last;
          last = clks;
        end
        if (!started && tx_s == 1'b0) started = 1;
        if (started && !dn_s && n < 64) begin
          got[n] = tx_s;
          n++;
        end
      end
      if (dn_s) fin = 1;
    end
    ok = fin ? 1 : 0;
  endtask

  typedef struct {
    int         dut;
    logic [7:0] data;
    int         tmode;
    int         nbits;
    logic [63:0] frame;
    int         clks;
    int         gmin;
    int         gmax;
  } vec_t;

  vec_t vt[6];

  logic [63:0] got;
  int n, clks, lead, gmin, gmax, ok, seen;

  initial begin
    vt[0] = '{0, 8'hA5,  4, 10, 64'b1_10100101_0,   40, 4, 4};
    vt[1] = '{0, 8'h00, -1, 10, 64'b1_00000000_0,   76, 7, 8};
    vt[2] = '{1, 8'hA5,  4, 11, 64'b1_0_10100101_0, 44, 4, 4};
    vt[3] = '{2, 8'hA5,  4, 11, 64'b1_1_10100101_0, 44, 4, 4};
    vt[4] = '{1, 8'h01,  4, 11, 64'b1_1_00000001_0, 44, 4, 4};
    vt[5] = '{0, 8'h3C,  2, 10, 64'b1_00111100_0,   20, 2, 2};

    #3 rstn = 1'b0;
    #1;
    check("rst_u0", {tx_w[0], rdy_w[0], bsy_w[0], dn_w[0]}, 4'b1100);
    check("rst_u3", {tx_w[3], rdy_w[3], bsy_w[3], dn_w[3]}, 4'b1100);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Idle ticks must leave the line high
    tmode = 1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (tx_w[0] !== 1'b1 || bsy_w[0] !== 1'b0) seen++;
    end
    check("idle_tick", seen, 0);

    for (int i = 0; i < 6; i++) begin
      tmode = vt[i].tmode;
      tcnt  = 0;
      facc  = 0;
      send(vt[i].dut, vt[i].data);
      capture(got, n, clks, lead, gmin, gmax, ok);
      check($sformatf("done%0d", i), ok, 1);
      check($sformatf("frame%0d", i), got, vt[i].frame);
      check($sformatf("nbits%0d", i), n, vt[i].nbits);
      check($sformatf("clks%0d", i), clks, vt[i].clks);
      check($sformatf("gap%0d", i), {gmin[7:0], gmax[7:0]},
            {vt[i].gmin[7:0], vt[i].gmax[7:0]});
      @(posedge clk);
      #1;
      check($sformatf("end%0d", i), {dn_s, rdy_s, bsy_s}, 3'b010);
    end

    // Back-to-back with din_valid held high
    sel = 0;
    tmode = 4;
    @(negedge clk);
    #1;
    din  = 8'h55;
    v[0] = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_acc1", {rdy_s, bsy_s}, 2'b01);
    din = 8'h0F;
    capture(got, n, clks, lead, gmin, gmax, ok);
    check("b2b_f1", got, 64'b1_01010101_0);
    @(posedge clk);
    #1;
    check("b2b_acc2", {rdy_s, bsy_s}, 2'b01);
    v[0] = 1'b0;
    din = 8'hFF;
    capture(got, n, clks, lead, gmin, gmax, ok);
    check("b2b_lead", lead, 3);
    check("b2b_f2", got, 64'b1_00001111_0);

    // Reset in the middle of data bit 3
    repeat (3) @(posedge clk);
    send(0, 8'h00);
    seen = 0;
    for (int c = 0; c < 200 && seen < 5; c++) begin
      @(posedge clk);
      #1;
      if (tick && (seen > 0 || tx_s == 1'b0)) seen++;
    end
    check("pre_rst", {tx_s, bsy_s}, 2'b01);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_rst", {tx_s, rdy_s, bsy_s, dn_s}, 4'b1100);
    @(negedge clk);
    rstn = 1'b1;
    send(0, 8'h5A);
    capture(got, n, clks, lead, gmin, gmax, ok);
    check("post_rst", got, 64'b1_01011010_0);
    check("post_rst_n", n, 10);

    // Accept coincident with a tick, 3 ticks/bit, two stop bits
    sel = 3;
    tmode = 2;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (tick) seen = 1;
    end
    din  = 8'h00;
    v[3] = 1'b1;
    @(posedge clk);
    #1;
    v[3] = 1'b0;
    check("coin_acc", {tick, rdy_s, bsy_s, tx_s}, 4'b1011);
    capture(got, n, clks, lead, gmin, gmax, ok);
    check("coin_lead", lead, 2);
    check("coin_frame", got, 64'h1_F800_0000);
    check("coin_n", n, 33);
    check("coin_clks", clks, 66);
    check("coin_done", ok, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
